// File: rtl/move_sequencer_if.sv
// Data-memory port bundle between the move sequencer (master) and the memory (slave).
// Reads are combinational on raddr; writes are one word per cycle when write_en is high.
`timescale 1ns/1ps
interface move_sequencer_if #(
  parameter int SIZE = 16,
  parameter int AW   = 6
);
  logic [AW-1:0]   waddr;
  logic [SIZE-1:0] write_data;
  logic            write_en;
  logic [AW-1:0]   raddr;
  logic [SIZE-1:0] read_data;

  modport master (output waddr, output write_data, output write_en, output raddr, input read_data);
  modport slave  (input waddr, input write_data, input write_en, input raddr, output read_data);
endinterface

// File: rtl/move_sequencer.sv
// Game-move controller: polls joystick/button words, moves the 3x3 selection cursor,
// places pieces into the player grids, toggles the turn word and clears the board.
`timescale 1ns/1ps
module move_sequencer #(
  parameter int SIZE           = 16,
  parameter int AW             = 6,
  parameter int JOYSTICK_ADDR  = 0,
  parameter int BUTTON_ADDR    = 29,
  parameter int PLAYER0_START  = 1,
  parameter int SELECTED_START = 10,
  parameter int PLAYER1_START  = 19,
  parameter int TURN_ADDR      = 28,
  parameter int CURSOR_RESET   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  move_sequencer_if.master      bus,
  output logic [3:0]            cursor,
  output logic                  turn,
  output logic                  busy,
  output logic                  move_done,
  output logic                  move_reject
);

  localparam logic [3:0] S_CLR      = 4'd0;
  localparam logic [3:0] S_SEL_INIT = 4'd1;
  localparam logic [3:0] S_POLL_J   = 4'd2;
  localparam logic [3:0] S_MOVE_CLR = 4'd3;
  localparam logic [3:0] S_MOVE_SET = 4'd4;
  localparam logic [3:0] S_POLL_B   = 4'd5;
  localparam logic [3:0] S_CHK0     = 4'd6;
  localparam logic [3:0] S_CHK1     = 4'd7;
  localparam logic [3:0] S_WR_CELL  = 4'd8;
  localparam logic [3:0] S_WR_TURN  = 4'd9;

  localparam logic [AW-1:0] JOY_A  = AW'(JOYSTICK_ADDR);
  localparam logic [AW-1:0] BTN_A  = AW'(BUTTON_ADDR);
  localparam logic [AW-1:0] P0_A   = AW'(PLAYER0_START);
  localparam logic [AW-1:0] SEL_A  = AW'(SELECTED_START);
  localparam logic [AW-1:0] P1_A   = AW'(PLAYER1_START);
  localparam logic [AW-1:0] TURN_A = AW'(TURN_ADDR);
  localparam logic [AW-1:0] CLR_FIRST = AW'(1);
  localparam logic [3:0]    CUR_RST   = 4'(CURSOR_RESET);

  logic [3:0]      state_reg, state_next;
  logic [AW-1:0]   clr_addr_reg, clr_addr_next;
  logic [3:0]      cursor_reg, cursor_next;
  logic [3:0]      new_cursor_reg, new_cursor_next;
  logic            turn_reg, turn_next;
  logic            joy_prev_reg, joy_prev_next;
  logic            btn_prev_reg, btn_prev_next;
  logic            clear_pending_reg, clear_pending_next;
  logic            we_reg, we_next;
  logic [AW-1:0]   waddr_reg, waddr_next;
  logic [SIZE-1:0] wdata_reg, wdata_next;
  logic            done_reg, done_next;
  logic            reject_reg, reject_next;
  logic [AW-1:0]   raddr_c;

  logic [3:0] dir;
  logic       dir_any;
  logic       btn;
  logic       cell_taken;
  logic [3:0] target;

  assign dir        = bus.read_data[3:0];
  assign dir_any    = |dir;
  assign btn        = bus.read_data[0];
  assign cell_taken = |bus.read_data;

  // Highest-priority direction wins (up > down > left > right); edges clamp, no wrap.
  function automatic logic [3:0] step_cursor(input logic [3:0] c, input logic [3:0] d);
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] res;
    if (c >= 4'd6) begin
      row = 2'd2;
      col = c - 4'd6;
    end else if (c >= 4'd3) begin
      row = 2'd1;
      col = c - 4'd3;
    end else begin
      row = 2'd0;
      col = c;
    end
    res = c;
    if (d[0]) begin
      if (row != 2'd0) res = c - 4'd3;
    end else if (d[1]) begin
      if (row != 2'd2) res = c + 4'd3;
    end else if (d[2]) begin
      if (col != 4'd0) res = c - 4'd1;
    end else if (d[3]) begin
      if (col != 4'd2) res = c + 4'd1;
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [AW-1:0] base, input logic [3:0] c);
    return base + AW'(c);
  endfunction

  assign target = step_cursor(cursor_reg, dir);

  always_comb begin
    state_next         = state_reg;
    clr_addr_next      = clr_addr_reg;
    cursor_next        = cursor_reg;
    new_cursor_next    = new_cursor_reg;
    turn_next          = turn_reg;
    joy_prev_next      = joy_prev_reg;
    btn_prev_next      = btn_prev_reg;
    clear_pending_next = clear_pending_reg | clear_req;
    we_next            = 1'b0;
    waddr_next         = waddr_reg;
    wdata_next         = wdata_reg;
    done_next          = 1'b0;
    reject_next        = 1'b0;
    raddr_c            = JOY_A;

    case (state_reg)
      S_CLR: begin
        we_next     = 1'b1;
        waddr_next  = clr_addr_reg;
        wdata_next  = '0;
        turn_next   = 1'b0;
        cursor_next = CUR_RST;
        if (clr_addr_reg == TURN_A) begin
          state_next = S_SEL_INIT;
        end else begin
          clr_addr_next = clr_addr_reg + AW'(1);
        end
      end

      S_SEL_INIT: begin
        we_next    = 1'b1;
        waddr_next = cell_addr(SEL_A, cursor_reg);
        wdata_next = SIZE'(1);
        state_next = S_POLL_J;
      end

      S_POLL_J: begin
        raddr_c       = JOY_A;
        joy_prev_next = dir_any;
        if (clear_pending_reg || clear_req) begin
          state_next         = S_CLR;
          clr_addr_next      = CLR_FIRST;
          clear_pending_next = 1'b0;
        end else if (dir_any && !joy_prev_reg && (target != cursor_reg)) begin
          new_cursor_next = target;
          state_next      = S_MOVE_CLR;
        end else begin
          // Covers no edge as well as a clamped move: nothing to write.
          state_next = S_POLL_B;
        end
      end

      S_MOVE_CLR: begin
        we_next    = 1'b1;
        waddr_next = cell_addr(SEL_A, cursor_reg);
        wdata_next = '0;
        state_next = S_MOVE_SET;
      end

      S_MOVE_SET: begin
        we_next     = 1'b1;
        waddr_next  = cell_addr(SEL_A, new_cursor_reg);
        wdata_next  = SIZE'(1);
        cursor_next = new_cursor_reg;
        state_next  = S_POLL_B;
      end

      S_POLL_B: begin
        raddr_c       = BTN_A;
        btn_prev_next = btn;
        state_next    = (btn && !btn_prev_reg) ? S_CHK0 : S_POLL_J;
      end

      S_CHK0: begin
        raddr_c = cell_addr(P0_A, cursor_reg);
        if (cell_taken) begin
          reject_next = 1'b1;
          state_next  = S_POLL_J;
        end else begin
          state_next = S_CHK1;
        end
      end

      S_CHK1: begin
        raddr_c = cell_addr(P1_A, cursor_reg);
        if (cell_taken) begin
          reject_next = 1'b1;
          state_next  = S_POLL_J;
        end else begin
          state_next = S_WR_CELL;
        end
      end

      S_WR_CELL: begin
        we_next    = 1'b1;
        waddr_next = cell_addr(turn_reg ? P1_A : P0_A, cursor_reg);
        wdata_next = SIZE'(1);
        state_next = S_WR_TURN;
      end

      S_WR_TURN: begin
        we_next    = 1'b1;
        waddr_next = TURN_A;
        wdata_next = {{(SIZE-1){1'b0}}, ~turn_reg};
        turn_next  = ~turn_reg;
        done_next  = 1'b1;
        state_next = S_POLL_J;
      end

      default: begin
        state_next    = S_CLR;
        clr_addr_next = CLR_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_CLR;
      clr_addr_reg      <= CLR_FIRST;
      cursor_reg        <= CUR_RST;
      new_cursor_reg    <= CUR_RST;
      turn_reg          <= 1'b0;
      joy_prev_reg      <= 1'b0;
      btn_prev_reg      <= 1'b0;
      clear_pending_reg <= 1'b0;
      we_reg            <= 1'b0;
      waddr_reg         <= '0;
      wdata_reg         <= '0;
      done_reg          <= 1'b0;
      reject_reg        <= 1'b0;
    end else begin
      state_reg         <= state_next;
      clr_addr_reg      <= clr_addr_next;
      cursor_reg        <= cursor_next;
      new_cursor_reg    <= new_cursor_next;
      turn_reg          <= turn_next;
      joy_prev_reg      <= joy_prev_next;
      btn_prev_reg      <= btn_prev_next;
      clear_pending_reg <= clear_pending_next;
      we_reg            <= we_next;
      waddr_reg         <= waddr_next;
      wdata_reg         <= wdata_next;
      done_reg          <= done_next;
      reject_reg        <= reject_next;
    end
  end

  assign bus.write_en   = we_reg;
  assign bus.waddr      = waddr_reg;
  assign bus.write_data = wdata_reg;
  assign bus.raddr      = raddr_c;
  assign cursor         = cursor_reg;
  assign turn           = turn_reg;
  assign busy           = (state_reg != S_POLL_J) && (state_reg != S_POLL_B);
  assign move_done      = done_reg;
  assign move_reject    = reject_reg;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: models the data memory and walks through
// clear, cursor moves, placement, rejection, clear request and async reset.
`timescale 1ns/1ps
module tb_move_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_req = 1'b0;
  logic [3:0] cursor;
  logic turn, busy, move_done, move_reject;

  logic [15:0] joy_word = 16'h0000;
  logic [15:0] btn_word = 16'h0000;
  logic [15:0] mem [64];

  int total = 0;
  int bad = 0;

  move_sequencer_if #(.SIZE(16), .AW(6)) bus ();

  move_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req   (clear_req),
    .bus         (bus),
    .cursor      (cursor),
    .turn        (turn),
    .busy        (busy),
    .move_done   (move_done),
    .move_reject (move_reject)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write_en) mem[bus.waddr] <= bus.write_data;
  end

  assign bus.read_data = (bus.raddr == 6'd0)  ? joy_word :
                         (bus.raddr == 6'd29) ? btn_word : mem[bus.raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_write(input string tag, input int a, input int d);
    $display("write %s: en=%0d addr=%0d data=%0h", tag, bus.write_en, bus.waddr, bus.write_data);
    chk({tag, "_we"}, 32'(bus.write_en), 32'd1);
    chk({tag, "_addr"}, 32'(bus.waddr), 32'(a));
    chk({tag, "_data"}, 32'(bus.write_data), 32'(d));
  endtask

  task automatic step_write(input string tag, input int a, input int d);
    step();
    chk_write(tag, a, d);
  endtask

  task automatic wait_write(input string tag, input int a, input int d);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.write_en && n < 20);
    chk_write(tag, a, d);
  endtask

  task automatic expect_no_write(input string tag, input int n);
    int w = 0;
    repeat (n) begin
      step();
      if (bus.write_en) w++;
    end
    $display("quiet %s: writes=%0d over %0d cycles", tag, w, n);
    chk(tag, 32'(w), 32'd0);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_we"}, 32'(bus.write_en), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.write_data), 32'd0);
    chk({tag, "_raddr"}, 32'(bus.raddr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_cursor"}, 32'(cursor), 32'd4);
    chk({tag, "_turn"}, 32'(turn), 32'd0);
    chk({tag, "_done"}, 32'(move_done), 32'd0);
    chk({tag, "_reject"}, 32'(move_reject), 32'd0);
  endtask

  initial begin
    int n;
    int w;

    // Reset state
    #12;
    reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Power-on clear pass followed by selection at the centre
    for (int i = 1; i <= 28; i++) step_write("clr", i, 0);
    step_write("sel_init", 14, 1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_cursor", 32'(cursor), 32'd4);
    chk("init_turn", 32'(turn), 32'd0);

    // Right: 4 -> 5
    joy_word = 16'h0008;
    wait_write("right_clr", 14, 0);
    step_write("right_set", 15, 1);
    chk("right_cursor", 32'(cursor), 32'd5);
    expect_no_write("hold_right", 10);
    joy_word = 16'h0000;
    run(4);
    // Right at column 2 is clamped
    joy_word = 16'h0008;
    expect_no_write("clamp_right", 10);
    chk("clamp_cursor", 32'(cursor), 32'd5);
    joy_word = 16'h0000;
    run(4);

    // Left back to the centre
    joy_word = 16'h0004;
    wait_write("left_clr", 15, 0);
    step_write("left_set", 14, 1);
    chk("left_cursor", 32'(cursor), 32'd4);
    joy_word = 16'h0000;
    run(4);

    // Player 0 places on cell 4
    btn_word = 16'h0001;
    wait_write("place0_cell", 5, 1);
    step_write("place0_turn", 28, 1);
    chk("place0_done", 32'(move_done), 32'd1);
    step();
    chk("place0_done_pulse", 32'(move_done), 32'd0);
    chk("place0_turnout", 32'(turn), 32'd1);
    chk("place0_mem5", 32'(mem[5]), 32'd1);
    btn_word = 16'h0000;
    run(4);

    // Same cell again is refused
    btn_word = 16'h0001;
    n = 0;
    w = 0;
    do begin
      step();
      n++;
      if (bus.write_en) w++;
    end while (!move_reject && n < 20);
    $display("reject: pulse=%0d writes=%0d", move_reject, w);
    chk("reject_pulse", 32'(move_reject), 32'd1);
    chk("reject_writes", 32'(w), 32'd0);
    step();
    chk("reject_pulse_end", 32'(move_reject), 32'd0);
    chk("reject_turn", 32'(turn), 32'd1);
    btn_word = 16'h0000;
    run(4);

    // Player 1: up then left to cell 0, then place
    joy_word = 16'h0001;
    wait_write("up_clr", 14, 0);
    step_write("up_set", 11, 1);
    joy_word = 16'h0000;
    run(4);
    joy_word = 16'h0004;
    wait_write("left2_clr", 11, 0);
    step_write("left2_set", 10, 1);
    chk("corner_cursor", 32'(cursor), 32'd0);
    joy_word = 16'h0000;
    run(4);
    btn_word = 16'h0001;
    wait_write("place1_cell", 19, 1);
    step_write("place1_turn", 28, 0);
    chk("place1_done", 32'(move_done), 32'd1);
    btn_word = 16'h0000;
    run(4);
    chk("place1_turnout", 32'(turn), 32'd0);

    // Move to cell 1, then request a clear while the piece is being written
    joy_word = 16'h0008;
    wait_write("right2_clr", 10, 0);
    step_write("right2_set", 11, 1);
    joy_word = 16'h0000;
    run(4);
    btn_word = 16'h0001;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.raddr != 6'd20 && n < 20);
    chk("chk1_raddr", 32'(bus.raddr), 32'd20);
    step();
    clear_req = 1'b1;
    step_write("clrq_cell", 2, 1);
    clear_req = 1'b0;
    step_write("clrq_turn", 28, 1);
    chk("clrq_done", 32'(move_done), 32'd1);
    wait_write("clrq_clr1", 1, 0);
    for (int i = 2; i <= 28; i++) step_write("clrq_clr", i, 0);
    step_write("clrq_sel", 14, 1);
    step();
    chk("clrq_mem28", 32'(mem[28]), 32'd0);
    chk("clrq_mem2", 32'(mem[2]), 32'd0);
    chk("clrq_mem19", 32'(mem[19]), 32'd0);
    chk("clrq_cursor", 32'(cursor), 32'd4);
    chk("clrq_turn", 32'(turn), 32'd0);
    btn_word = 16'h0000;
    run(4);

    // Asynchronous reset in the middle of a cursor move
    joy_word = 16'h0008;
    n = 0;
    do begin
      step();
      n++;
    end while (!busy && n < 20);
    step_write("arst_pre", 14, 0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_values("arst");
    joy_word = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_write("arst_clr1", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
